// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-channel stream multiplexer: mode encodings and
// the modulo-N index increment used by the round-robin pointer.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter for stream_mux_n: owns the rotating priority pointer and
// returns the first requesting channel at or after it (wrapping modulo N_CH).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_valid;

  // Scanning from the farthest offset down lets the nearest requester win last.
  always_comb begin
    w_idx         = '0;
    w_grant       = '0;
    w_grant_valid = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_idx = SEL_W'((int'(r_ptr) + k) % N_CH);
      if (req[w_idx]) begin
        w_grant       = w_idx;
        w_grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= SEL_W'(wrap_inc(32'(w_grant), N_CH));
    end
  end

  assign grant       = w_grant;
  assign grant_valid = w_grant_valid;

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Define STREAM_MUX_RR_EN to compile in round-robin arbitration (mode=1).
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_ch;

  logic             w_load_en;
  logic             w_sel_ok;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_valid;
  logic             w_transfer;
  logic [N_CH-1:0]  w_in_ready;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_sel_ok  = int'(sel) < N_CH;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] w_rr_grant;
  logic             w_rr_grant_valid;
  logic             w_rr_mode;

  assign w_rr_mode = (mode == MODE_RR);

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (w_transfer && w_rr_mode),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_grant_valid)
  );

  assign w_grant       = w_rr_mode ? w_rr_grant       : sel;
  assign w_grant_valid = w_rr_mode ? w_rr_grant_valid : w_sel_ok;
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_grant       = sel;
  assign w_grant_valid = w_sel_ok;
`endif

  assign w_transfer = w_grant_valid && in_valid[w_grant] && w_load_en;

  // Ready goes only to the granted channel, so at most one bit is ever set.
  always_comb begin
    w_in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_in_ready[i] = w_load_en && w_grant_valid && (int'(w_grant) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[int'(w_grant)*W +: W];
      r_out_ch    <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: a transaction-level reference model is
// compared every cycle, plus hand-computed literal expectations per scenario.
module tb_stream_mux_n;

  localparam int N_CH  = 4;
  localparam int W     = 4;
  localparam int SEL_W = 2;

`ifdef STREAM_MUX_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_ready;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  bit          mValid;
  int unsigned mData;
  int unsigned mCh;
  int unsigned mPtr;

  stream_mux_n #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned got, input int unsigned exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Which channel the spec rules grant right now; -1 when none.
  function automatic int modelGrant();
    if (RR_BUILD && mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (in_valid[(mPtr + k) % N_CH]) return int'((mPtr + k) % N_CH);
      end
      return -1;
    end
    return (int'(sel) < N_CH) ? int'(sel) : -1;
  endfunction

  function automatic int unsigned modelReady();
    int g;
    g = modelGrant();
    if ((mValid && !out_ready) || g < 0) return 0;
    return 1 << g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      mValid = 1'b0;
      mData  = 0;
      mCh    = 0;
      mPtr   = 0;
    end else begin
      g = modelGrant();
      if (g >= 0 && in_valid[g] && (!mValid || out_ready)) begin
        mValid = 1'b1;
        mData  = (in_data >> (g * W)) & ((1 << W) - 1);
        mCh    = g;
        if (RR_BUILD && mode) mPtr = (g + 1) % N_CH;
      end else if (out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model out_valid", out_valid, mValid);
    checkOutput("model in_ready", in_ready, modelReady());
    if (mValid) begin
      checkOutput("model out_data", out_data, mData);
      checkOutput("model out_ch", out_ch, mCh);
    end
  end

  task automatic applyStimulus(input logic [N_CH-1:0] v, input logic m,
                               input logic [SEL_W-1:0] s, input logic ordy);
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    in_data = {4'hD, 4'hC, 4'hB, 4'hA};
    rst_n   = 1'b0;
    applyStimulus(4'hF, 1'b0, 2'd2, 1'b1);
    step();
    step();
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_ch", out_ch, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready sel2", in_ready, 4'b0100);

    // Explicit select, one word per cycle
    for (int s = 0; s < 4; s++) begin
      applyStimulus(4'hF, 1'b0, SEL_W'(s), 1'b1);
      step();
      checkOutput("explicit out_data", out_data, 10 + s);
      checkOutput("explicit out_ch", out_ch, s);
      checkOutput("explicit out_valid", out_valid, 1);
    end

    // Backpressure holds the word regardless of sel
    applyStimulus(4'hF, 1'b0, 2'd1, 1'b1);
    step();
    checkOutput("bp load", out_data, 4'hB);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'hF, 1'b0, SEL_W'(c * 2 % 4), 1'b0);
      #1;
      checkOutput("bp in_ready", in_ready, 0);
      step();
      checkOutput("bp hold data", out_data, 4'hB);
      checkOutput("bp hold ch", out_ch, 1);
    end
    applyStimulus(4'hF, 1'b0, 2'd3, 1'b1);
    #1;
    checkOutput("bp release in_ready", in_ready, 4'b1000);
    step();
    checkOutput("bp no-bubble data", out_data, 4'hD);
    checkOutput("bp no-bubble valid", out_valid, 1);
    applyStimulus(4'h0, 1'b0, 2'd0, 1'b1);
    step();
    checkOutput("drain out_valid", out_valid, 0);

    // Round-robin, all channels valid: 0,1,2,3,0 then 1,2,3 to bring ptr back to 0
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'hF, 1'b1, 2'd0, 1'b1);
      step();
`ifdef STREAM_MUX_RR_EN
      checkOutput("rr full out_ch", out_ch, c % 4);
`endif
    end

    // Round-robin, sparse requests on channels 1 and 3
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1);
      step();
`ifdef STREAM_MUX_RR_EN
      checkOutput("rr sparse out_ch", out_ch, (c % 2) ? 3 : 1);
      checkOutput("rr sparse out_data", out_data, (c % 2) ? 4'hD : 4'hB);
`endif
    end

    // Asynchronous reset while a word is held
    applyStimulus(4'hF, 1'b1, 2'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset out_data", out_data, 0);
    rst_n = 1'b1;
    applyStimulus(4'hF, 1'b1, 2'd2, 1'b1);
    step();
`ifdef STREAM_MUX_RR_EN
    checkOutput("ptr cleared by reset", out_ch, 0);
`else
    checkOutput("mode ignored out_ch", out_ch, 2);
`endif

    // Mixed traffic against the model
    for (int c = 0; c < 60; c++) begin
      in_data = N_CH*W'($urandom);
      applyStimulus(N_CH'($urandom), 1'($urandom), SEL_W'($urandom), ($urandom_range(0, 3) != 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
